// File: rtl/e1_rx_bd_pkg.sv
// Shared definitions for the E1 receive buffer-descriptor scheduler.
// A completion entry packs the MF index in the low bits and the CRC status in the top two bits.
package e1_rx_bd_pkg;

  localparam int CRC_E_W    = 2;
  localparam int CRC_E_SMF1 = 0;
  localparam int CRC_E_SMF2 = 1;

  typedef enum logic [1:0] {
    RETIRE_IDLE     = 2'd0,
    RETIRE_ACCEPT   = 2'd1,
    RETIRE_DROP     = 2'd2,
    RETIRE_SPURIOUS = 2'd3
  } retire_e;

endpackage

// File: rtl/e1_rx_bd_fifo.sv
// Synchronous FIFO with flush.
// When it is full, a push is still accepted if the head is popped in the same cycle.
module e1_rx_bd_fifo #(
  parameter int WIDTH      = 8,
  parameter int LOG2_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [LOG2_DEPTH:0] wr_ptr;
  logic [LOG2_DEPTH:0] rd_ptr;
  logic [WIDTH-1:0]    mem [DEPTH];
  logic                pop_ok;
  logic                push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[LOG2_DEPTH] != rd_ptr[LOG2_DEPTH]) &&
                   (wr_ptr[LOG2_DEPTH-1:0] == rd_ptr[LOG2_DEPTH-1:0]);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the head is forced to zero while empty instead.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr[LOG2_DEPTH-1:0]] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr[LOG2_DEPTH-1:0]];

endmodule

// File: rtl/e1_rx_bd_ctrl.sv
// E1 receive BD scheduler: presents the submit-queue head to the receiver and retires it on bd_done.
// Retired entries go into a completion queue tagged with the CRC status; misses and errors are counted.
module e1_rx_bd_ctrl
  import e1_rx_bd_pkg::*;
#(
  parameter int MFW        = 7,
  parameter int LOG2_DEPTH = 2,
  parameter int MISS_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ctl_enable,
  input  logic               ctl_flush,
  input  logic [MFW-1:0]     sub_mf,
  input  logic               sub_valid,
  output logic               sub_ready,
  output logic [MFW-1:0]     cmp_mf,
  output logic [CRC_E_W-1:0] cmp_crc_e,
  output logic               cmp_valid,
  input  logic               cmp_ready,
  output logic [MFW-1:0]     bd_mf,
  output logic               bd_valid,
  input  logic [CRC_E_W-1:0] bd_crc_e,
  input  logic               bd_done,
  input  logic               bd_miss,
  output logic [MISS_W-1:0]  stat_miss_cnt,
  output logic               stat_cmp_ovf,
  output logic               stat_spurious,
  input  logic               stat_clear
);

  localparam int CW = MFW + CRC_E_W;

  logic          sub_full;
  logic          sub_empty;
  logic [MFW-1:0] sub_head;
  logic          cmp_full;
  logic          cmp_empty;
  logic [CW-1:0] cmp_head;
  logic          cmp_pop;
  logic          cmp_push;
  retire_e       retire;

  e1_rx_bd_fifo #(.WIDTH(MFW), .LOG2_DEPTH(LOG2_DEPTH)) u_sub_q (
    .clk       (clk),
    .rst       (rst),
    .push      (sub_valid),
    .push_data (sub_mf),
    .pop       (bd_done),
    .flush     (ctl_flush),
    .full      (sub_full),
    .empty     (sub_empty),
    .head      (sub_head)
  );

  // A flushed retire loses both its pop and its completion.
  always_comb begin
    retire = RETIRE_IDLE;
    if (bd_done) begin
      if (sub_empty)                  retire = RETIRE_SPURIOUS;
      else if (ctl_flush)             retire = RETIRE_IDLE;
      else if (!cmp_full || cmp_pop)  retire = RETIRE_ACCEPT;
      else                            retire = RETIRE_DROP;
    end
  end

  assign cmp_pop  = cmp_ready & ~cmp_empty;
  assign cmp_push = (retire == RETIRE_ACCEPT);

  e1_rx_bd_fifo #(.WIDTH(CW), .LOG2_DEPTH(LOG2_DEPTH)) u_cmp_q (
    .clk       (clk),
    .rst       (rst),
    .push      (cmp_push),
    .push_data ({bd_crc_e, sub_head}),
    .pop       (cmp_pop),
    .flush     (1'b0),
    .full      (cmp_full),
    .empty     (cmp_empty),
    .head      (cmp_head)
  );

  assign sub_ready = ~sub_full;
  assign bd_valid  = ctl_enable & ~sub_empty;
  assign bd_mf     = sub_head;
  assign cmp_valid = ~cmp_empty;
  assign cmp_mf    = cmp_head[MFW-1:0];
  assign cmp_crc_e = cmp_head[CW-1:MFW];

  // Events take precedence over a coincident stat_clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_miss_cnt <= '0;
      stat_cmp_ovf  <= 1'b0;
      stat_spurious <= 1'b0;
    end else begin
      if (bd_miss) begin
        if (stat_clear)               stat_miss_cnt <= {{(MISS_W-1){1'b0}}, 1'b1};
        else if (~&stat_miss_cnt)     stat_miss_cnt <= stat_miss_cnt + 1'b1;
      end else if (stat_clear) begin
        stat_miss_cnt <= '0;
      end

      if (retire == RETIRE_DROP)          stat_cmp_ovf <= 1'b1;
      else if (stat_clear)                stat_cmp_ovf <= 1'b0;

      if (retire == RETIRE_SPURIOUS)      stat_spurious <= 1'b1;
      else if (stat_clear)                stat_spurious <= 1'b0;
    end
  end

endmodule

// File: tb/tb_e1_rx_bd_ctrl.sv
// Directed bench for e1_rx_bd_ctrl: queue ordering, full/overflow, flush, miss saturation, enable and reset.
module tb_e1_rx_bd_ctrl;

  localparam int MFW    = 7;
  localparam int MISS_W = 4;

  logic              clk = 1'b0;
  logic              rst, ctl_enable, ctl_flush;
  logic [MFW-1:0]    sub_mf;
  logic              sub_valid, sub_ready;
  logic [MFW-1:0]    cmp_mf;
  logic [1:0]        cmp_crc_e;
  logic              cmp_valid, cmp_ready;
  logic [MFW-1:0]    bd_mf;
  logic              bd_valid;
  logic [1:0]        bd_crc_e;
  logic              bd_done, bd_miss;
  logic [MISS_W-1:0] stat_miss_cnt;
  logic              stat_cmp_ovf, stat_spurious, stat_clear;

  int total = 0;
  int bad   = 0;

  e1_rx_bd_ctrl #(.MFW(MFW), .LOG2_DEPTH(2), .MISS_W(MISS_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .ctl_enable    (ctl_enable),
    .ctl_flush     (ctl_flush),
    .sub_mf        (sub_mf),
    .sub_valid     (sub_valid),
    .sub_ready     (sub_ready),
    .cmp_mf        (cmp_mf),
    .cmp_crc_e     (cmp_crc_e),
    .cmp_valid     (cmp_valid),
    .cmp_ready     (cmp_ready),
    .bd_mf         (bd_mf),
    .bd_valid      (bd_valid),
    .bd_crc_e      (bd_crc_e),
    .bd_done       (bd_done),
    .bd_miss       (bd_miss),
    .stat_miss_cnt (stat_miss_cnt),
    .stat_cmp_ovf  (stat_cmp_ovf),
    .stat_spurious (stat_spurious),
    .stat_clear    (stat_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [MFW-1:0] mf);
    sub_mf = mf; sub_valid = 1'b1;
    tick();
    sub_valid = 1'b0;
  endtask

  task automatic done(input logic [1:0] crc);
    bd_crc_e = crc; bd_done = 1'b1;
    tick();
    bd_done = 1'b0; bd_crc_e = 2'b00;
  endtask

  logic [MFW-1:0] exp_mf  [4] = '{7'd1, 7'd2, 7'd3, 7'd6};
  logic [1:0]     exp_crc [4] = '{2'd0, 2'd1, 2'd2, 2'd1};

  initial begin
    rst = 1'b1; ctl_enable = 1'b1; ctl_flush = 1'b0; sub_mf = '0; sub_valid = 1'b0;
    cmp_ready = 1'b0; bd_crc_e = '0; bd_done = 1'b0; bd_miss = 1'b0; stat_clear = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_sub_ready", sub_ready, 1);
    chk("rst_cmp_valid", cmp_valid, 0);
    chk("rst_bd_valid", bd_valid, 0);
    chk("rst_bd_mf", bd_mf, 0);
    chk("rst_cmp_mf", cmp_mf, 0);
    chk("rst_cmp_crc", cmp_crc_e, 0);
    chk("rst_miss", stat_miss_cnt, 0);
    chk("rst_ovf", stat_cmp_ovf, 0);
    chk("rst_spur", stat_spurious, 0);

    // basic submit / retire
    push(7'd5);
    chk("t1_bd_valid", bd_valid, 1);
    chk("t1_bd_mf5", bd_mf, 5);
    push(7'd9);
    done(2'b10);
    chk("t1_cmp_valid", cmp_valid, 1);
    chk("t1_cmp_mf", cmp_mf, 5);
    chk("t1_cmp_crc", cmp_crc_e, 2'b10);
    chk("t1_bd_mf9", bd_mf, 9);
    chk("t1_bd_valid2", bd_valid, 1);
    cmp_ready = 1'b1; tick(); cmp_ready = 1'b0;
    chk("t1_cmp_popped", cmp_valid, 0);

    // fill submit queue, then push and retire together while full
    push(7'd1); push(7'd2); push(7'd3);
    chk("t2_full", sub_ready, 0);
    sub_mf = 7'd4; sub_valid = 1'b1; bd_crc_e = 2'b11; bd_done = 1'b1;
    #1;
    chk("t2_ready_low_same", sub_ready, 0);
    tick();
    sub_valid = 1'b0; bd_done = 1'b0;
    chk("t2_still_full", sub_ready, 0);
    chk("t2_bd_mf1", bd_mf, 1);
    chk("t2_cmp_mf9", cmp_mf, 9);
    chk("t2_cmp_crc3", cmp_crc_e, 3);
    done(2'd0); done(2'd1); done(2'd2);
    chk("t2_last_is_4", bd_mf, 4);
    chk("t2_ovf_clean", stat_cmp_ovf, 0);

    // completion queue full: drop, then accept with simultaneous pop
    done(2'd3);
    chk("t3_ovf", stat_cmp_ovf, 1);
    chk("t3_head_popped", bd_valid, 0);
    chk("t3_cmp_head", cmp_mf, 9);
    stat_clear = 1'b1; tick(); stat_clear = 1'b0;
    chk("t3_ovf_clr", stat_cmp_ovf, 0);
    push(7'd6);
    cmp_ready = 1'b1; done(2'd1); cmp_ready = 1'b0;
    chk("t3_no_ovf", stat_cmp_ovf, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain_valid", cmp_valid, 1);
      chk("t3_drain_mf", cmp_mf, exp_mf[i]);
      chk("t3_drain_crc", cmp_crc_e, exp_crc[i]);
      cmp_ready = 1'b1; tick(); cmp_ready = 1'b0;
    end
    chk("t3_drained", cmp_valid, 0);

    // flush with coincident push and retire
    push(7'd7); push(7'd8);
    chk("t4_bd_mf7", bd_mf, 7);
    ctl_flush = 1'b1; sub_mf = 7'd11; sub_valid = 1'b1; bd_done = 1'b1;
    tick();
    ctl_flush = 1'b0; sub_valid = 1'b0; bd_done = 1'b0;
    chk("t4_flush_bd_valid", bd_valid, 0);
    chk("t4_flush_no_cmp", cmp_valid, 0);
    chk("t4_flush_sub_ready", sub_ready, 1);
    chk("t4_no_spur_yet", stat_spurious, 0);
    done(2'd3);
    chk("t4_spur", stat_spurious, 1);
    chk("t4_spur_no_cmp", cmp_valid, 0);
    stat_clear = 1'b1; done(2'd0); stat_clear = 1'b0;
    chk("t4_spur_wins", stat_spurious, 1);
    stat_clear = 1'b1; tick(); stat_clear = 1'b0;
    chk("t4_spur_clr", stat_spurious, 0);

    // miss counter
    bd_miss = 1'b1; repeat (3) tick(); bd_miss = 1'b0;
    chk("t5_miss3", stat_miss_cnt, 3);
    bd_miss = 1'b1; stat_clear = 1'b1; tick(); bd_miss = 1'b0; stat_clear = 1'b0;
    chk("t5_miss_clr_event", stat_miss_cnt, 1);
    stat_clear = 1'b1; tick(); stat_clear = 1'b0;
    chk("t5_miss_clr", stat_miss_cnt, 0);
    bd_miss = 1'b1; repeat (20) tick(); bd_miss = 1'b0;
    chk("t5_miss_sat", stat_miss_cnt, 15);

    // enable gating, then reset mid-operation
    stat_clear = 1'b1; tick(); stat_clear = 1'b0;
    push(7'd5); push(7'd12);
    ctl_enable = 1'b0; tick();
    chk("t6_gated", bd_valid, 0);
    done(2'd1);
    chk("t6_cmp_mf5", cmp_mf, 5);
    chk("t6_cmp_crc1", cmp_crc_e, 1);
    chk("t6_cmp_valid", cmp_valid, 1);
    chk("t6_still_gated", bd_valid, 0);
    ctl_enable = 1'b1; tick();
    chk("t6_bd_valid", bd_valid, 1);
    chk("t6_bd_mf12", bd_mf, 12);
    bd_miss = 1'b1; tick(); bd_miss = 1'b0;
    chk("t6_miss1", stat_miss_cnt, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_rst_bd_valid", bd_valid, 0);
    chk("t6_rst_cmp_valid", cmp_valid, 0);
    chk("t6_rst_miss", stat_miss_cnt, 0);
    chk("t6_rst_sub_ready", sub_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
